// File: rtl/branch_predict_tracker.sv
// rtl/branch_predict_tracker.sv - in-order branch prediction record FIFO driving 2-bit counter updates
// Records (index, prediction) at fetch; each resolve pops the oldest record into one update pulse.
module branch_predict_tracker #(
  parameter int s_index = 3,
  parameter int depth   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fetch_valid,
  input  logic [s_index-1:0]      fetch_index,
  output logic [s_index-1:0]      read_index,
  input  logic [1:0]              counter_in,
  output logic                    predict_taken,
  output logic                    push_ready,
  input  logic                    resolve_valid,
  input  logic                    resolve_taken,
  input  logic                    flush,
  output logic                    increment,
  output logic                    decrement,
  output logic [s_index-1:0]      write_index,
  output logic                    mispredict,
  output logic [$clog2(depth):0]  count
);
  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;

  // Each entry is {index, pred}; pred sits in bit 0.
  logic [s_index:0]     mem_q [depth];
  logic [s_index:0]     mem_d [depth];
  logic [ptr_w-1:0]     head_q, head_d;
  logic [ptr_w-1:0]     tail_q, tail_d;
  logic [cnt_w-1:0]     count_q, count_d;
  logic                 increment_q, increment_d;
  logic                 decrement_q, decrement_d;
  logic                 mispredict_q, mispredict_d;
  logic [s_index-1:0]   write_index_q, write_index_d;
  logic                 do_push, do_pop, miss;
  logic                 unused_counter_lsb;

  assign read_index         = fetch_index;
  assign predict_taken      = counter_in[1];
  assign unused_counter_lsb = counter_in[0];
  assign push_ready         = (count_q != cnt_w'(depth));

  assign do_pop  = resolve_valid && (count_q != '0);
  assign miss    = do_pop && (mem_q[head_q][0] != resolve_taken);
  // A mispredict or flush squashes the whole window, including this cycle's fetch.
  assign do_push = fetch_valid && push_ready && !flush && !miss;

  always_comb begin
    mem_d         = mem_q;
    head_d        = head_q + ptr_w'(do_pop);
    tail_d        = tail_q + ptr_w'(do_push);
    count_d       = count_q + cnt_w'(do_push) - cnt_w'(do_pop);
    increment_d   = do_pop && resolve_taken;
    decrement_d   = do_pop && !resolve_taken;
    mispredict_d  = miss;
    write_index_d = write_index_q;
    if (do_pop) begin
      write_index_d = mem_q[head_q][s_index:1];
    end
    if (do_push) begin
      mem_d[tail_q] = {fetch_index, counter_in[1]};
    end
    if (flush || miss) begin
      head_d  = tail_q;
      tail_d  = tail_q;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      increment_q   <= 1'b0;
      decrement_q   <= 1'b0;
      mispredict_q  <= 1'b0;
      write_index_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      increment_q   <= increment_d;
      decrement_q   <= decrement_d;
      mispredict_q  <= mispredict_d;
      write_index_q <= write_index_d;
    end
  end

  assign increment   = increment_q;
  assign decrement   = decrement_q;
  assign mispredict  = mispredict_q;
  assign write_index = write_index_q;
  assign count       = count_q;

endmodule

// File: tb/tb_branch_predict_tracker.sv
// tb/tb_branch_predict_tracker.sv - directed scoreboard bench for branch_predict_tracker
module tb_branch_predict_tracker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_valid = 1'b0;
  logic [2:0] fetch_index = '0;
  logic [2:0] read_index;
  logic [1:0] counter_in = '0;
  logic       predict_taken;
  logic       push_ready;
  logic       resolve_valid = 1'b0;
  logic       resolve_taken = 1'b0;
  logic       flush = 1'b0;
  logic       increment, decrement, mispredict;
  logic [2:0] write_index;
  logic [2:0] count;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic       mis;
    logic [2:0] widx;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model[$];
  logic [2:0] exp_widx = '0;
  int         checks = 0;
  int         failures = 0;

  branch_predict_tracker #(.s_index(3), .depth(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_index(fetch_index), .read_index(read_index),
    .counter_in(counter_in), .predict_taken(predict_taken), .push_ready(push_ready),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
    .increment(increment), .decrement(decrement), .write_index(write_index),
    .mispredict(mispredict), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic fv, input logic [2:0] fi, input logic [1:0] cin,
                       input logic rv, input logic rt, input logic fl);
    exp_t       e;
    logic [3:0] h;
    int         pre;
    logic       pop, mis, pok;
    fetch_valid = fv; fetch_index = fi; counter_in = cin;
    resolve_valid = rv; resolve_taken = rt; flush = fl;
    #1;
    chk("read_index", 32'(read_index), 32'(fi));
    chk("predict_taken", 32'(predict_taken), 32'(cin[1]));
    pre = model.size();
    chk("push_ready", 32'(push_ready), 32'(pre != 4));
    pop = rv && (pre != 0);
    mis = 1'b0;
    e.inc = 1'b0; e.dec = 1'b0; e.mis = 1'b0;
    if (pop) begin
      h = model.pop_front();
      mis = (h[0] != rt);
      exp_widx = h[3:1];
      e.inc = rt; e.dec = !rt; e.mis = mis;
    end
    e.widx = exp_widx;
    pok = fv && (pre < 4) && !fl && !mis;
    if (fl || mis) model.delete();
    else if (pok) model.push_back({fi, cin[1]});
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("increment", 32'(increment), 32'(e.inc));
    chk("decrement", 32'(decrement), 32'(e.dec));
    chk("mispredict", 32'(mispredict), 32'(e.mis));
    chk("write_index", 32'(write_index), 32'(e.widx));
    chk("count", 32'(count), 32'(model.size()));
  endtask

  task automatic do_reset();
    reset = 1'b1; fetch_valid = 1'b1; fetch_index = 3'd6; counter_in = 2'b11;
    resolve_valid = 1'b1; resolve_taken = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; fetch_valid = 1'b0; resolve_valid = 1'b0;
    model.delete(); sb.delete(); exp_widx = '0;
    chk("rst_increment", 32'(increment), 32'd0);
    chk("rst_decrement", 32'(decrement), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_write_index", 32'(write_index), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_push_ready", 32'(push_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // correct taken prediction
    cycle(1, 3'd5, 2'b10, 0, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 0, 0, 0);

    // weakly not-taken predicted, actually taken
    cycle(1, 3'd3, 2'b01, 0, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);

    // mispredict discards younger entries; later resolve is ignored
    cycle(1, 3'd1, 2'b00, 0, 0, 0);
    cycle(1, 3'd2, 2'b00, 0, 0, 0);
    cycle(1, 3'd3, 2'b01, 0, 0, 0);
    cycle(1, 3'd7, 2'b11, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);

    // fill, overflow drop, wrap, ordered drain
    cycle(1, 3'd4, 2'b11, 0, 0, 0);
    cycle(1, 3'd5, 2'b10, 0, 0, 0);
    cycle(1, 3'd6, 2'b00, 0, 0, 0);
    cycle(1, 3'd7, 2'b01, 0, 0, 0);
    cycle(1, 3'd0, 2'b11, 0, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);
    cycle(1, 3'd1, 2'b11, 0, 0, 0);
    cycle(1, 3'd2, 2'b00, 0, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);

    // simultaneous push and pop at count 2, then resolve on empty
    cycle(1, 3'd6, 2'b10, 0, 0, 0);
    cycle(1, 3'd7, 2'b00, 0, 0, 0);
    cycle(1, 3'd4, 2'b10, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);
    cycle(0, 3'd0, 2'b00, 1, 0, 0);

    // flush with same-cycle resolve and fetch
    cycle(1, 3'd1, 2'b11, 0, 0, 0);
    cycle(1, 3'd2, 2'b11, 0, 0, 0);
    cycle(1, 3'd3, 2'b11, 0, 0, 0);
    cycle(1, 3'd2, 2'b11, 1, 1, 1);
    cycle(0, 3'd0, 2'b00, 1, 1, 0);

    // reset mid-stream
    cycle(1, 3'd5, 2'b10, 0, 0, 0);
    cycle(1, 3'd6, 2'b10, 0, 0, 0);
    cycle(1, 3'd7, 2'b10, 0, 0, 0);
    do_reset();
    cycle(0, 3'd0, 2'b00, 1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_predict_tracker.md
Name: branch_predict_tracker

Overview:
- Sits between fetch/execute and the direct-indexed 2-bit saturating counter array.
- At fetch, it reads the counter at the branch index, forms the taken/not-taken prediction and records (index, prediction) in an in-order FIFO.
- At branch resolution, it pops the oldest record and drives the counter array's increment/decrement/write_index.
- On a misprediction it flags the event and discards all younger in-flight predictions.

Parameters:
- s_index, 3, width of the counter-array index (array has 2**s_index entries).
- depth, 4, number of in-flight predictions tracked (power of 2, >= 2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- fetch_valid  input  1  branch fetched this cycle; request to record a prediction
- fetch_index  input  s_index  counter-array index for the fetched branch
- read_index  output  s_index  to counter-array read_index; combinational copy of fetch_index
- counter_in  input  2  counter-array out for read_index
- predict_taken  output  1  combinational counter_in[1]
- push_ready  output  1  high when FIFO not full
- resolve_valid  input  1  oldest in-flight branch resolved this cycle
- resolve_taken  input  1  actual branch outcome
- flush  input  1  external pipeline flush; discards all in-flight records
- increment  output  1  to counter array; registered one-cycle pulse
- decrement  output  1  to counter array; registered one-cycle pulse
- write_index  output  s_index  to counter array; registered
- mispredict  output  1  registered one-cycle pulse
- count  output  $clog2(depth)+1  number of valid FIFO entries

Behaviour:
- Storage: circular FIFO of depth entries, each {index, pred}, with head/tail pointers wrapping modulo depth. count is registered.
- Push: fetch_valid && push_ready stores {fetch_index, counter_in[1]} at tail on the clock edge.
  - fetch_valid while full is dropped silently.
  - push_ready depends only on registered count, never on same-cycle resolve.
- Pop: resolve_valid && count!=0 pops the head. On the next edge:
  - write_index <= head.index
  - increment <= resolve_taken
  - decrement <= !resolve_taken
  - mispredict <= (head.pred != resolve_taken)
  - Latency is one cycle, resolve to update pulse.
- resolve_valid while empty: ignored. increment, decrement and mispredict stay 0; write_index holds its value.
- Idle cycles: increment, decrement and mispredict are 0; write_index holds its last value.
- Counter saturation at 00/11 is the array's job; this block always pulses on every pop.
- Mispredict recovery: when a popped entry mispredicts, all remaining entries are discarded on that same edge.
  - count <= 0, head = tail.
  - A push in the same cycle is also dropped.
- Simultaneous push and pop, no mispredict, not full: both happen; count unchanged.
- flush: count <= 0 and head = tail on the next edge.
  - A same-cycle resolve still pops the head and emits its update pulse.
  - A same-cycle push is dropped.
- reset: priority over everything else.
  - count <= 0, head = tail = 0.
  - increment, decrement, mispredict <= 0; write_index <= 0.
  - No update is emitted for a resolve that arrives in the reset cycle.
- Only increment or decrement is ever high, never both; each update is a single-cycle pulse.

Test Plan:
- Reset, then fetch idx 5 with counter_in=2'b10 (predict_taken=1); next cycle resolve_taken=1 -> one cycle later increment=1, write_index=5, mispredict=0, count returns to 0.
- Fetch idx 3 with counter_in=2'b01; resolve_taken=1 -> decrement=0, increment=1, write_index=3, mispredict=1.
- Mispredict flushing: push idx 1,2,3 (preds 0,0,0); resolve_taken=1 -> mispredict=1 for idx 1, count=0; a following resolve_valid produces no pulse.
- Full/wrap: push 4 entries (count=4, push_ready=0); 5th push is dropped; pop 2 and push 2 more (pointer wrap) -> indices pop in exact push order.
- Simultaneous push+pop at count=2 with correct prediction -> count stays 2, one update pulse; resolve on empty -> no pulse.
- Flush with same-cycle resolve at count=3 -> head update pulse emitted, count=0; reset mid-stream with count=3 -> count=0, all pulses 0 next cycle.
